kros_ctrl: RTL and testbench

//  Front-end controller for the KROS LED sequencer. Synchronises and debounces the four

---
 rtl/kros_ctrl.sv | 156 +++++++++++++++
 tb/tb_kros_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kros_ctrl.sv
// kros_ctrl -- front-end controller for the KROS LED sequencer.
//
// Turns the four raw active-low board pushbuttons into clean press events,
// keeps the selected sequence index (wrapping) and speed index (saturating),
// and divides CLK_50 down to the one-cycle step tick that advances the
// pattern engine. Everything lives in the CLK_50 domain.
//
// Ports:
//   CLK_50      in   1         system clock, 50 MHz
//   reset       in   1         synchronous, active-high reset
//   pb_freq_up  in   1         raw button, active low (0 = pressed)
//   pb_freq_dn  in   1         raw button, active low
//   pb_seq_up   in   1         raw button, active low
//   pb_seq_dn   in   1         raw button, active low
//   seq_sel     out  SEQ_W     current sequence index, wraps 0..NUM_SEQ-1
//   freq_sel    out  FREQ_W    current speed index, saturates 0..NUM_FREQ-1 (higher = faster)
//   tick        out  1         one-cycle step enable for the pattern engine
//   seq_chg     out  1         pulse in the cycle seq_sel shows its new value
//   freq_chg    out  1         pulse in the cycle freq_sel shows its new value

module kros_ctrl #(
  parameter int DEB_CYCLES = 1000,
  parameter int NUM_SEQ    = 8,
  parameter int NUM_FREQ   = 8,
  parameter int FREQ_INIT  = 3,
  parameter int BASE_DIV   = 50
) (
  input  logic                        CLK_50,
  input  logic                        reset,
  input  logic                        pb_freq_up,
  input  logic                        pb_freq_dn,
  input  logic                        pb_seq_up,
  input  logic                        pb_seq_dn,
  output logic [$clog2(NUM_SEQ)-1:0]  seq_sel,
  output logic [$clog2(NUM_FREQ)-1:0] freq_sel,
  output logic                        tick,
  output logic                        seq_chg,
  output logic                        freq_chg
);

  localparam int SEQ_W      = $clog2(NUM_SEQ);
  localparam int FREQ_W     = $clog2(NUM_FREQ);
  localparam int CNT_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int MAX_PERIOD = BASE_DIV << (NUM_FREQ - 1);
  // Wide enough for MAX_PERIOD-1, the largest value div_cnt ever holds.
  localparam int DIV_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;

  localparam int B_FU = 0;
  localparam int B_FD = 1;
  localparam int B_SU = 2;
  localparam int B_SD = 3;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(NUM_SEQ - 1);
  localparam logic [FREQ_W-1:0] FREQ_LAST = FREQ_W'(NUM_FREQ - 1);

  logic [3:0]       pb_raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       press;
  logic [CNT_W-1:0] deb_cnt [4];

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  period_m1;
  logic [FREQ_W-1:0] shift_amt;

  assign pb_raw = {pb_seq_dn, pb_seq_up, pb_freq_dn, pb_freq_up};

  // Button pipeline: two-flop synchroniser, debounce and press detect.
  // The debounce counter only runs while the synchronised level disagrees
  // with the accepted level, so any bounce back resets it. stable_d holds
  // the previous accepted level so a press is reported one cycle after the
  // accepted level falls, and a release (0->1) never produces an event.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      press    <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1    <= pb_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Index registers. Opposing presses in the same cycle cancel out, and a
  // speed press at the end stop is swallowed without a change pulse.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      seq_sel  <= '0;
      freq_sel <= FREQ_W'(FREQ_INIT);
      seq_chg  <= 1'b0;
      freq_chg <= 1'b0;
    end else begin
      seq_chg  <= 1'b0;
      freq_chg <= 1'b0;

      if (press[B_SU] && !press[B_SD]) begin
        seq_sel <= (seq_sel == SEQ_LAST) ? '0 : seq_sel + 1'b1;
        seq_chg <= 1'b1;
      end else if (press[B_SD] && !press[B_SU]) begin
        seq_sel <= (seq_sel == '0) ? SEQ_LAST : seq_sel - 1'b1;
        seq_chg <= 1'b1;
      end

      if (press[B_FU] && !press[B_FD] && (freq_sel != FREQ_LAST)) begin
        freq_sel <= freq_sel + 1'b1;
        freq_chg <= 1'b1;
      end else if (press[B_FD] && !press[B_FU] && (freq_sel != '0)) begin
        freq_sel <= freq_sel - 1'b1;
        freq_chg <= 1'b1;
      end
    end
  end

  // Period halves for every step up in speed; the fastest speed runs at
  // BASE_DIV cycles per tick.
  always_comb begin
    shift_amt = FREQ_LAST - freq_sel;
    period_m1 = DIV_W'((32'(BASE_DIV) << shift_amt) - 32'd1);
  end

  // Tick is a decode of the divider. In a freq_chg cycle the old count may
  // already exceed the new period, so the tick is suppressed and the count
  // restarts, giving the first new-speed tick exactly one new period later.
  assign tick = (div_cnt == period_m1) && !freq_chg;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (freq_chg || (div_cnt == period_m1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kros_ctrl.sv
// tb_kros_ctrl -- self-checking bench for kros_ctrl.
//
// Button stimulus pushes the index change it should cause (kind, value and
// the cycle it must appear in) onto a scoreboard queue; a negedge monitor
// pops an entry for every seq_chg/freq_chg pulse and also checks the tick
// spacing against the period implied by the expected speed index.

module tb_kros_ctrl;

  localparam int DEB_CYCLES = 4;
  localparam int NUM_SEQ    = 4;
  localparam int NUM_FREQ   = 4;
  localparam int FREQ_INIT  = 1;
  localparam int BASE_DIV   = 2;

  localparam int B_FU = 0;
  localparam int B_FD = 1;
  localparam int B_SU = 2;
  localparam int B_SD = 3;

  // Raw low sampled at edge 0 -> index visible after edge DEB_CYCLES+3;
  // stimulus is driven 2 time units after an edge, so add one more.
  localparam int PRESS_LAT = DEB_CYCLES + 4;
  localparam int IDLE_CYC  = 40;

  typedef struct {
    int kind;
    int value;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pb;
  logic [1:0] seq_sel;
  logic [1:0] freq_sel;
  logic       tick;
  logic       seq_chg;
  logic       freq_chg;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   anchor = 0;
  int   period;
  int   model_seq;
  int   model_freq;

  kros_ctrl #(
    .DEB_CYCLES(DEB_CYCLES),
    .NUM_SEQ   (NUM_SEQ),
    .NUM_FREQ  (NUM_FREQ),
    .FREQ_INIT (FREQ_INIT),
    .BASE_DIV  (BASE_DIV)
  ) dut (
    .CLK_50    (clk),
    .reset     (reset),
    .pb_freq_up(pb[B_FU]),
    .pb_freq_dn(pb[B_FD]),
    .pb_seq_up (pb[B_SU]),
    .pb_seq_dn (pb[B_SD]),
    .seq_sel   (seq_sel),
    .freq_sel  (freq_sel),
    .tick      (tick),
    .seq_chg   (seq_chg),
    .freq_chg  (freq_chg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tperiod(input int f);
    return BASE_DIV << (NUM_FREQ - 1 - f);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic popCheck(input int kind, input logic [31:0] val, input logic pulse);
    exp_t item;
    if (sb.size() == 0) begin
      checkOutput((kind == 0) ? "spurious_seq_chg" : "spurious_freq_chg", 32'(pulse), 0);
    end else begin
      item = sb.pop_front();
      checkOutput("chg_kind", kind, item.kind);
      checkOutput("chg_value", val, item.value);
      checkOutput("chg_cycle", cyc, item.due);
      if (item.kind == 1) period = tperiod(item.value);
    end
  endtask

  // Monitor: scoreboard pops on change pulses, tick spacing checks.
  always @(negedge clk) begin
    if (reset) begin
      anchor = cyc;
      period = tperiod(FREQ_INIT);
    end else begin
      if (seq_chg) popCheck(0, 32'(seq_sel), seq_chg);
      if (freq_chg) begin
        popCheck(1, 32'(freq_sel), freq_chg);
        checkOutput("tick_on_chg", 32'(tick), 0);
        anchor = cyc;
      end else if (tick) begin
        checkOutput("tick_period", cyc - anchor, period);
        anchor = cyc;
      end else if (cyc - anchor > period) begin
        checkOutput("tick_missing", cyc - anchor, period);
        anchor = cyc;
      end
    end
  end

  task automatic pushExp(input int kind, input int value);
    exp_t item;
    item.kind  = kind;
    item.value = value;
    item.due   = cyc + PRESS_LAT;
    sb.push_back(item);
  endtask

  task automatic checkLevels();
    checkOutput("seq_level", 32'(seq_sel), model_seq);
    checkOutput("freq_level", 32'(freq_sel), model_freq);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_seq_sel", 32'(seq_sel), 0);
    checkOutput("rst_freq_sel", 32'(freq_sel), FREQ_INIT);
    checkOutput("rst_tick", 32'(tick), 0);
    checkOutput("rst_seq_chg", 32'(seq_chg), 0);
    checkOutput("rst_freq_chg", 32'(freq_chg), 0);
  endtask

  // Press the buttons in mask together for hold cycles, release, let the
  // pipeline settle, then check the scoreboard drained and levels match.
  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    @(posedge clk);
    #2;
    if (mask[B_SU] && !mask[B_SD]) begin
      model_seq = (model_seq + 1) % NUM_SEQ;
      pushExp(0, model_seq);
    end else if (mask[B_SD] && !mask[B_SU]) begin
      model_seq = (model_seq + NUM_SEQ - 1) % NUM_SEQ;
      pushExp(0, model_seq);
    end
    if (mask[B_FU] && !mask[B_FD] && model_freq < NUM_FREQ - 1) begin
      model_freq++;
      pushExp(1, model_freq);
    end else if (mask[B_FD] && !mask[B_FU] && model_freq > 0) begin
      model_freq--;
      pushExp(1, model_freq);
    end
    pb = pb & ~mask;
    repeat (hold) @(posedge clk);
    #2;
    pb = pb | mask;
    repeat (IDLE_CYC) @(posedge clk);
    #2;
    checkOutput("sb_drain", sb.size(), 0);
    sb.delete();
    checkLevels();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    pb         = 4'hF;
    model_seq  = 0;
    model_freq = FREQ_INIT;
    period     = tperiod(FREQ_INIT);

    // Reset for three edges, then idle so the monitor sees several ticks.
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues();
    repeat (30) @(posedge clk);

    // Bouncing seq_up never reaches the debounce limit, then a long hold.
    for (int r = 0; r < 5; r++) begin
      @(posedge clk);
      #2;
      pb[B_SU] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      pb[B_SU] = 1'b1;
    end
    applyStimulus(4'b0100, 100);

    // seq_up wraps 1,2,3,0 ... wait, start from 1: go 2,3,0 then dn 0->3.
    for (int r = 0; r < 3; r++) applyStimulus(4'b0100, 20);
    applyStimulus(4'b1000, 20);
    applyStimulus(4'b0100, 20);
    applyStimulus(4'b0100, 20);
    applyStimulus(4'b0100, 20);
    applyStimulus(4'b0100, 20);
    applyStimulus(4'b1000, 20);

    // Speed up to saturation, then down to saturation.
    for (int r = 0; r < 3; r++) applyStimulus(4'b0001, 20);
    for (int r = 0; r < 4; r++) applyStimulus(4'b0010, 20);

    // Opposing buttons falling together cancel.
    applyStimulus(4'b1100, 20);
    applyStimulus(4'b0011, 20);

    // Reset pulse while seq_up is mid-debounce; the held button must still
    // be accepted after a full debounce from the reset release.
    @(posedge clk);
    #2;
    pb[B_SU] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    model_seq  = 0;
    model_freq = FREQ_INIT;
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_seq = 1;
    pushExp(0, model_seq);
    @(negedge clk);
    checkResetValues();
    repeat (20) @(posedge clk);
    #2;
    pb[B_SU] = 1'b1;
    repeat (IDLE_CYC) @(posedge clk);
    #2;
    checkOutput("sb_drain", sb.size(), 0);
    checkLevels();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
